// File: rtl/alu_defs.sv
// Shared opcode constants, FSM state encoding and width helper for the
// sequential N-bit ALU.
package alu_defs;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MULT = 1'b1
  } state_t;

  // Ceiling log2: bits needed to count 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_nbit.sv
// Parametrised ripple-carry adder; also exposes the carry into the MSB so
// the caller can form the signed-overflow flag.
module add_nbit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             carry_msb
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout      = c[WIDTH];
  assign carry_msb = c[WIDTH-1];

endmodule

// File: rtl/alu_nbit_seq.sv
// N-bit MIPS-style ALU: single-cycle ADD/SUB/XOR/SLT and a shift-add unsigned
// MUL taking WIDTH cycles. Start is accepted only in IDLE; Done pulses once per result.
module alu_nbit_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Cntrl,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Hi,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output state_t           fsm_state
);

  localparam int CW = clog2(WIDTH + 1);

  state_t state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [CW-1:0]      count;
  logic               accept;
  logic               mul_last;

  // Shared ADD/SUB/SLT adder: SUB and SLT use A + ~B + 1.
  logic [WIDTH-1:0] alu_b, alu_sum;
  logic             alu_cin, alu_cout, alu_cmsb, alu_ovf, slt_bit;

  always_comb begin
    alu_cin = (Cntrl != OP_ADD);
    alu_b   = alu_cin ? ~B : B;
    alu_ovf = alu_cmsb ^ alu_cout;
    slt_bit = alu_sum[WIDTH-1] ^ alu_ovf;
  end

  add_nbit #(.WIDTH(WIDTH)) u_alu_add (
    .a         (A),
    .b         (alu_b),
    .cin       (alu_cin),
    .sum       (alu_sum),
    .cout      (alu_cout),
    .carry_msb (alu_cmsb)
  );

  // Multiplier accumulate: upper half plus multiplicand when product LSB is set.
  logic [WIDTH-1:0] mul_addend, acc_sum;
  logic             acc_cout, acc_cmsb_unused;

  always_comb begin
    mul_addend = prod[0] ? mcand : '0;
    prod_next  = {acc_cout, acc_sum, prod[WIDTH-1:1]};
  end

  add_nbit #(.WIDTH(WIDTH)) u_mul_add (
    .a         (prod[2*WIDTH-1:WIDTH]),
    .b         (mul_addend),
    .cin       (1'b0),
    .sum       (acc_sum),
    .cout      (acc_cout),
    .carry_msb (acc_cmsb_unused)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (Start && Cntrl == OP_MUL) state_next = S_MULT;
      S_MULT: if (mul_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    Busy      = (state == S_MULT);
    accept    = Start && (state == S_IDLE);
    mul_last  = (state == S_MULT) && (count == CW'(WIDTH - 1));
    fsm_state = state;
  end

  assign Zero = (Out == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Out      <= '0;
      Hi       <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
      mcand    <= '0;
      prod     <= '0;
      count    <= '0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        case (Cntrl)
          OP_ADD, OP_SUB: begin
            Out <= alu_sum; Hi <= '0; Cout <= alu_cout; Overflow <= alu_ovf; Done <= 1'b1;
          end
          OP_XOR: begin
            Out <= A ^ B; Hi <= '0; Cout <= 1'b0; Overflow <= 1'b0; Done <= 1'b1;
          end
          OP_SLT: begin
            Out <= {{(WIDTH-1){1'b0}}, slt_bit}; Hi <= '0; Cout <= 1'b0; Overflow <= 1'b0;
            Done <= 1'b1;
          end
          OP_MUL: begin
            mcand <= A;
            prod  <= {{WIDTH{1'b0}}, B};
            count <= '0;
          end
          default: begin
            Out <= '0; Hi <= '0; Cout <= 1'b0; Overflow <= 1'b0; Done <= 1'b1;
          end
        endcase
      end else if (state == S_MULT) begin
        prod  <= prod_next;
        count <= count + CW'(1);
        if (mul_last) begin
          Out      <= prod_next[WIDTH-1:0];
          Hi       <= prod_next[2*WIDTH-1:WIDTH];
          Overflow <= |prod_next[2*WIDTH-1:WIDTH];
          Cout     <= 1'b0;
          Done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed-vector bench for alu_nbit_seq at WIDTH=32 with hand-computed results.
module tb_alu_nbit_seq;
  import alu_defs::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         Start;
  logic [W-1:0] A, B;
  logic [2:0]   Cntrl;
  logic [W-1:0] Out, Hi;
  logic         Cout, Overflow, Zero, Busy, Done;
  state_t       fsm_state;

  int total = 0;
  int bad   = 0;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .A         (A),
    .B         (B),
    .Cntrl     (Cntrl),
    .Out       (Out),
    .Hi        (Hi),
    .Cout      (Cout),
    .Overflow  (Overflow),
    .Zero      (Zero),
    .Busy      (Busy),
    .Done      (Done),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One single-cycle op; result is sampled 1ns after the accepting edge.
  task automatic run_single(input string tag, input logic [2:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_out, input logic exp_cout,
                            input logic exp_ovf);
    @(negedge clk);
    Start = 1'b1; Cntrl = op; A = a; B = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    chk({tag, "_done"}, Done, 1'b1);
    chk({tag, "_busy"}, Busy, 1'b0);
    chk({tag, "_out"},  Out, exp_out);
    chk({tag, "_hi"},   Hi, '0);
    chk({tag, "_cout"}, Cout, exp_cout);
    chk({tag, "_ovf"},  Overflow, exp_ovf);
    chk({tag, "_zero"}, Zero, exp_out == '0);
  endtask

  // Multiply; optionally injects an ADD request on busy cycle inject_at.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input int inject_at);
    int n;
    int extra;
    n = 0;
    extra = 0;
    @(negedge clk);
    Start = 1'b1; Cntrl = OP_MUL; A = a; B = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    while (Busy === 1'b1 && n < 200) begin
      if (Done === 1'b1) extra++;
      n++;
      if (n == inject_at) begin
        Start = 1'b1; Cntrl = OP_ADD; A = 1; B = 1;
      end else begin
        Start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    Start = 1'b0;
    chk({tag, "_busy_cycles"}, n, W);
    chk({tag, "_extra_done"}, extra, 0);
    chk({tag, "_done"}, Done, 1'b1);
    chk({tag, "_hi"},   Hi, exp_hi);
    chk({tag, "_lo"},   Out, exp_lo);
    chk({tag, "_ovf"},  Overflow, exp_hi != '0);
    chk({tag, "_cout"}, Cout, 1'b0);
    chk({tag, "_zero"}, Zero, exp_lo == '0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, Done, 1'b0);
    chk({tag, "_hold"}, Out, exp_lo);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; A = '0; B = '0; Cntrl = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",  Out, '0);
    chk("rst_hi",   Hi, '0);
    chk("rst_zero", Zero, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_flags", {Cout, Overflow}, 2'b00);
    chk("rst_state", fsm_state, S_IDLE);
    @(negedge clk);
    reset = 1'b0;

    run_single("add_ovf",   OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("add_done_pulse", Done, 1'b0);
    chk("add_hold", Out, 32'h80000000);

    // Back-to-back: each Start lands while the previous Done is high.
    run_single("sub_eq",    OP_SUB, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    run_single("sub_borrow",OP_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_single("slt_neg",   OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    run_single("slt_ovf",   OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
    run_single("slt_false", OP_SLT, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
    run_single("xor",       OP_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0, 1'b0);
    run_single("add_wrap",  OP_ADD, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1, 1'b0);
    run_single("add_plain", OP_ADD, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0);
    run_single("illegal",   3'b101, 32'd5, 32'd5, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("idle_done", Done, 1'b0);

    run_mul("mul_big",   32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 0);
    run_mul("mul_small", 32'd3, 32'd4, 32'h0, 32'd12, 0);
    run_mul("mul_inj",   32'h80000001, 32'd3, 32'h00000001, 32'h80000003, 10);

    // Asynchronous reset in the middle of a multiply, away from any edge.
    @(negedge clk);
    Start = 1'b1; Cntrl = OP_MUL; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    chk("pre_rst_busy", Busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_out",  Out, '0);
    chk("arst_hi",   Hi, '0);
    chk("arst_zero", Zero, 1'b1);
    chk("arst_busy", Busy, 1'b0);
    chk("arst_done", Done, 1'b0);
    chk("arst_ovf",  Overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_single("post_rst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
